// File: rtl/lsu_store_axi_if.sv
// AXI4-Lite write-only channel bundle (AW, W, B) between the store unit and memory.
interface lsu_store_axi_if #(
  parameter int DATA_LEN = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [DATA_LEN-1:0]     awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_LEN-1:0]     wdata;
  logic [DATA_LEN/8-1:0]   wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/lsu_store_axi.sv
// RV32 store unit: accepts one SB/SH/SW, replicates data across lanes, builds
// byte strobes, performs one AXI4-Lite write and reports completion or a trap.
module lsu_store_axi #(
  parameter int DATA_LEN       = 32,
  parameter int MISALIGN_CAUSE = 6,
  parameter int ACCESS_CAUSE   = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                store_valid,
  output logic                store_ready,
  input  logic [DATA_LEN-1:0] store_addr,
  input  logic [DATA_LEN-1:0] store_data,
  input  logic                is_byte,
  input  logic                is_half,
  input  logic                is_word,
  output logic                done,
  output logic                err,
  output logic [DATA_LEN-1:0] err_cause,
  lsu_store_axi_if.master     axi
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_B, S_FIN} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam int         PAY_W   = DATA_LEN + DATA_LEN/8;

  // Lane replication plus strobe generation; returns {wdata, wstrb}.
  function automatic logic [PAY_W-1:0] align_store(
    input logic [1:0]          sz,
    input logic [1:0]          off,
    input logic [DATA_LEN-1:0] d
  );
    logic [PAY_W-1:0] res;
    case (sz)
      SZ_BYTE: res = {{4{d[7:0]}}, (4'b0001 << off)};
      SZ_HALF: res = {{2{d[15:0]}}, (4'b0011 << off)};
      SZ_WORD: res = {d, 4'b1111};
      default: res = {d, 4'b1111};
    endcase
    return res;
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_aw_vld;
  logic                  r_w_vld;
  logic                  r_err;
  logic [DATA_LEN-1:0]   r_cause;
  logic [DATA_LEN-1:0]   r_addr;
  logic [DATA_LEN-1:0]   r_wdata;
  logic [DATA_LEN/8-1:0] r_wstrb;
  logic                  w_aw_nxt;
  logic                  w_w_nxt;
  logic                  w_err_nxt;
  logic [DATA_LEN-1:0]   w_cause_nxt;
  logic [1:0]            w_sz;
  logic                  w_misalign;
  logic                  w_accept;
  logic [PAY_W-1:0]      w_payload;

  // Size decode (word beats half beats byte, no flag means word) and alignment check.
  always_comb begin
    w_sz = SZ_WORD;
    if (is_word) begin
      w_sz = SZ_WORD;
    end else if (is_half) begin
      w_sz = SZ_HALF;
    end else if (is_byte) begin
      w_sz = SZ_BYTE;
    end else begin
      w_sz = SZ_WORD;
    end
    w_misalign = ((w_sz == SZ_HALF) && store_addr[0]) ||
                 ((w_sz == SZ_WORD) && (store_addr[1:0] != 2'b00));
    w_accept   = (r_state == S_IDLE) && store_valid;
    w_payload  = align_store(w_sz, store_addr[1:0], store_data);
  end

  // Next-state and next-output logic for the write sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_aw_nxt    = r_aw_vld;
    w_w_nxt     = r_w_vld;
    w_err_nxt   = r_err;
    w_cause_nxt = r_cause;
    case (r_state)
      S_IDLE: begin
        if (store_valid && w_misalign) begin
          w_state_nxt = S_FIN;
          w_err_nxt   = 1'b1;
          w_cause_nxt = DATA_LEN'(MISALIGN_CAUSE);
        end else if (store_valid) begin
          w_state_nxt = S_SEND;
          w_aw_nxt    = 1'b1;
          w_w_nxt     = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        w_aw_nxt = r_aw_vld & ~axi.awready;
        w_w_nxt  = r_w_vld & ~axi.wready;
        if (!w_aw_nxt && !w_w_nxt) begin
          w_state_nxt = S_WAIT_B;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      S_WAIT_B: begin
        if (axi.bvalid) begin
          w_state_nxt = S_FIN;
          w_err_nxt   = (axi.bresp != 2'b00);
          w_cause_nxt = (axi.bresp != 2'b00) ? DATA_LEN'(ACCESS_CAUSE) : {DATA_LEN{1'b0}};
        end else begin
          w_state_nxt = S_WAIT_B;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_err_nxt   = 1'b0;
        w_cause_nxt = {DATA_LEN{1'b0}};
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_aw_nxt    = 1'b0;
        w_w_nxt     = 1'b0;
        w_err_nxt   = 1'b0;
        w_cause_nxt = {DATA_LEN{1'b0}};
      end
    endcase
  end

  // State, handshake valids and trap status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_aw_vld <= 1'b0;
      r_w_vld  <= 1'b0;
      r_err    <= 1'b0;
      r_cause  <= {DATA_LEN{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_aw_vld <= w_aw_nxt;
      r_w_vld  <= w_w_nxt;
      r_err    <= w_err_nxt;
      r_cause  <= w_cause_nxt;
    end
  end

  // Request payload captured once at acceptance so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= {DATA_LEN{1'b0}};
      r_wdata <= {DATA_LEN{1'b0}};
      r_wstrb <= {(DATA_LEN/8){1'b0}};
    end else if (w_accept) begin
      r_addr  <= store_addr;
      r_wdata <= w_payload[PAY_W-1:DATA_LEN/8];
      r_wstrb <= w_payload[DATA_LEN/8-1:0];
    end
  end

  assign store_ready = (r_state == S_IDLE);
  assign done        = (r_state == S_FIN);
  assign err         = r_err;
  assign err_cause   = r_cause;
  assign axi.awvalid = r_aw_vld;
  assign axi.awaddr  = r_addr;
  assign axi.wvalid  = r_w_vld;
  assign axi.wdata   = r_wdata;
  assign axi.wstrb   = r_wstrb;
  assign axi.bready  = (r_state == S_WAIT_B);

endmodule

// File: tb/tb_lsu_store_axi.sv
// Scoreboard bench for lsu_store_axi: directed stores, configurable AXI slave,
// expected AW/W payloads and completions queued at issue, checked by a monitor.
module tb_lsu_store_axi;

  logic        clk;
  logic        rst_n;
  logic        store_valid;
  logic        store_ready;
  logic [31:0] store_addr;
  logic [31:0] store_data;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        done;
  logic        err;
  logic [31:0] err_cause;

  lsu_store_axi_if #(.DATA_LEN(32)) axi ();

  lsu_store_axi #(.DATA_LEN(32), .MISALIGN_CAUSE(6), .ACCESS_CAUSE(7)) dut (
    .clk(clk), .rst_n(rst_n), .store_valid(store_valid), .store_ready(store_ready),
    .store_addr(store_addr), .store_data(store_data), .is_byte(is_byte),
    .is_half(is_half), .is_word(is_word), .done(done), .err(err),
    .err_cause(err_cause), .axi(axi)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  bhw;
    logic        bus;
    logic [31:0] ewdata;
    logic [3:0]  ewstrb;
    logic        eerr;
    logic [31:0] ecause;
    int          lat;
    int          awd;
    int          wd;
    logic [1:0]  bresp;
    logic        early;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] cause;
    int          cyc;
  } done_exp_t;

  vec_t        vecs[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  done_exp_t   done_q[$];

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  int         cfg_awd   = 0;
  int         cfg_wd    = 0;
  logic [1:0] cfg_bresp = 2'b00;
  logic       cfg_early = 1'b0;
  logic       cfg_bhold = 1'b0;
  logic       aw_seen, w_seen, b_hs;
  int         aw_cnt, w_cnt;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Slave: record handshakes at the falling edge, where all signals are stable.
  initial begin
    aw_seen = 1'b0; w_seen = 1'b0; b_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_seen = 1'b0; w_seen = 1'b0; b_hs = 1'b0;
      end else begin
        if (axi.awvalid && axi.awready) aw_seen = 1'b1;
        if (axi.wvalid && axi.wready) w_seen = 1'b1;
        if (axi.bvalid && axi.bready) b_hs = 1'b1;
      end
    end
  end

  // Slave: drive ready/response just after each rising edge.
  initial begin
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    aw_cnt = 0; w_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0;
      end else begin
        if (axi.awvalid) begin
          axi.awready = (aw_cnt >= cfg_awd);
          aw_cnt++;
        end else begin
          axi.awready = 1'b0;
          aw_cnt = 0;
        end
        if (axi.wvalid) begin
          axi.wready = (w_cnt >= cfg_wd);
          w_cnt++;
        end else begin
          axi.wready = 1'b0;
          w_cnt = 0;
        end
        axi.bresp = cfg_bresp;
        if (b_hs) begin
          axi.bvalid = 1'b0;
          aw_seen = 1'b0; w_seen = 1'b0; b_hs = 1'b0;
        end else if (aw_seen && w_seen && !cfg_bhold) begin
          axi.bvalid = 1'b1;
        end else if (cfg_early && (axi.awvalid || axi.wvalid)) begin
          axi.bvalid = 1'b1;
        end else begin
          axi.bvalid = 1'b0;
        end
      end
    end
  end

  // Monitor: compare every presented payload and completion against the queues.
  initial begin
    done_exp_t de;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (axi.awvalid) begin
          if (aw_q.size() == 0) begin
            check("aw_unexpected", 64'(axi.awvalid), 64'd0);
          end else begin
            check("awaddr", 64'(axi.awaddr), 64'(aw_q[0]));
            if (axi.awready) void'(aw_q.pop_front());
          end
        end
        if (axi.wvalid) begin
          if (w_q.size() == 0) begin
            check("w_unexpected", 64'(axi.wvalid), 64'd0);
          end else begin
            check("wdata", 64'(axi.wdata), 64'(w_q[0][35:4]));
            check("wstrb", 64'(axi.wstrb), 64'(w_q[0][3:0]));
            if (axi.wready) void'(w_q.pop_front());
          end
        end
        if (axi.awvalid || axi.wvalid) check("bready_early", 64'(axi.bready), 64'd0);
        if (done) begin
          if (done_q.size() == 0) begin
            check("done_unexpected", 64'(done), 64'd0);
          end else begin
            de = done_q.pop_front();
            check("err", 64'(err), 64'(de.err));
            check("err_cause", 64'(err_cause), 64'(de.cause));
            check("done_cycle", 64'(cyc), 64'(de.cyc));
          end
        end else begin
          check("err_quiet", {31'd0, err, err_cause}, 64'd0);
        end
      end
    end
  end

  task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input logic [2:0] bhw,
                         input logic bus, input logic [31:0] ewd, input logic [3:0] ews,
                         input logic eerr, input logic [31:0] ec, input int lat,
                         input int awd, input int wd, input logic [1:0] br, input logic early);
    vec_t v;
    v.addr = a; v.data = d; v.bhw = bhw; v.bus = bus; v.ewdata = ewd; v.ewstrb = ews;
    v.eerr = eerr; v.ecause = ec; v.lat = lat; v.awd = awd; v.wd = wd; v.bresp = br;
    v.early = early;
    vecs.push_back(v);
  endtask

  task automatic issue(input vec_t v);
    done_exp_t de;
    int        i;
    cfg_awd = v.awd; cfg_wd = v.wd; cfg_bresp = v.bresp; cfg_early = v.early;
    @(negedge clk);
    for (i = 0; i < 20 && !store_ready; i++) @(negedge clk);
    check("ready_wait", 64'(store_ready), 64'd1);
    store_addr = v.addr; store_data = v.data;
    {is_byte, is_half, is_word} = v.bhw;
    store_valid = 1'b1;
    if (v.bus) begin
      aw_q.push_back(v.addr);
      w_q.push_back({v.ewdata, v.ewstrb});
    end
    de.err = v.eerr; de.cause = v.ecause; de.cyc = cyc + v.lat;
    done_q.push_back(de);
    @(posedge clk);
    #1;
    store_valid = 1'b0;
    store_addr = ~v.addr; store_data = ~v.data;
    {is_byte, is_half, is_word} = ~v.bhw;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && done_q.size() != 0; i++) @(negedge clk);
    check("done_pending", 64'(done_q.size()), 64'd0);
    check("aw_left", 64'(aw_q.size()), 64'd0);
    check("w_left", 64'(w_q.size()), 64'd0);
    done_q.delete(); aw_q.delete(); w_q.delete();
  endtask

  initial begin
    vec_t v6;
    // addr, data, {b,h,w}, bus, wdata, wstrb, err, cause, latency, aw_dly, w_dly, bresp, early_b
    add_vec(32'h8000_0010, 32'hDEAD_BEEF, 3'b001, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'd0, 3, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0003, 32'h1234_56AB, 3'b100, 1'b1, 32'hABAB_ABAB, 4'h8, 1'b0, 32'd0, 3, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0002, 32'h0000_CAFE, 3'b010, 1'b1, 32'hCAFE_CAFE, 4'hC, 1'b0, 32'd0, 3, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0002, 32'h1111_2222, 3'b001, 1'b0, 32'h0, 4'h0, 1'b1, 32'd6, 1, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0001, 32'h0000_3333, 3'b010, 1'b0, 32'h0, 4'h0, 1'b1, 32'd6, 1, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0003, 32'h0000_4444, 3'b010, 1'b0, 32'h0, 4'h0, 1'b1, 32'd6, 1, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0004, 32'h1122_3344, 3'b001, 1'b1, 32'h1122_3344, 4'hF, 1'b0, 32'd0, 6, 3, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0001, 32'h0000_00C3, 3'b100, 1'b1, 32'hC3C3_C3C3, 4'h2, 1'b0, 32'd0, 5, 0, 2, 2'b00, 1'b0);
    add_vec(32'h8000_000C, 32'h55AA_55AA, 3'b001, 1'b1, 32'h55AA_55AA, 4'hF, 1'b1, 32'd7, 5, 2, 0, 2'b10, 1'b1);
    add_vec(32'h8000_0008, 32'h0102_0304, 3'b000, 1'b1, 32'h0102_0304, 4'hF, 1'b0, 32'd0, 3, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0020, 32'h7788_99AA, 3'b111, 1'b1, 32'h7788_99AA, 4'hF, 1'b0, 32'd0, 3, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0006, 32'h0000_BEEF, 3'b110, 1'b1, 32'hBEEF_BEEF, 4'hC, 1'b0, 32'd0, 3, 0, 0, 2'b00, 1'b0);
    add_vec(32'h8000_0000, 32'h0000_005A, 3'b100, 1'b1, 32'h5A5A_5A5A, 4'h1, 1'b0, 32'd0, 3, 0, 0, 2'b11, 1'b0);

    rst_n = 1'b0; store_valid = 1'b0; store_addr = 32'h0; store_data = 32'h0;
    is_byte = 1'b0; is_half = 1'b0; is_word = 1'b0;
    #12;
    check("rst_ready", 64'(store_ready), 64'd1);
    check("rst_valids", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'd0);
    check("rst_done", {31'd0, done, err_cause} | {31'd0, err, 32'd0}, 64'd0);
    check("rst_payload", {axi.awaddr, axi.wdata} ^ {28'd0, axi.wstrb}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fix the last vector's expected error: bresp 2'b11 is also a fault.
    vecs[12].eerr = 1'b1;
    vecs[12].ecause = 32'd7;

    foreach (vecs[k]) begin
      issue(vecs[k]);
      wait_done();
    end

    // Reset while waiting for B: transaction abandoned, outputs back to reset values.
    v6 = vecs[0];
    cfg_bhold = 1'b1;
    issue(v6);
    for (int i = 0; i < 20 && !axi.bready; i++) @(negedge clk);
    check("reach_wait_b", 64'(axi.bready), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ready", 64'(store_ready), 64'd1);
    check("arst_valids", {61'd0, axi.awvalid, axi.wvalid, axi.bready}, 64'd0);
    check("arst_done", {30'd0, done, err, err_cause}, 64'd0);
    check("arst_payload", {axi.awaddr, axi.wdata}, 64'd0);
    check("arst_wstrb", 64'(axi.wstrb), 64'd0);
    done_q.delete(); aw_q.delete(); w_q.delete();
    cfg_bhold = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    issue(vecs[1]);
    wait_done();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
